// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: fixed-latency mult/multu/div/divu plus mthi/mtlo/mfhi/mflo.
// Optional abort port enabled by defining HILO_MDU_FLUSH_EN.
module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  HILOType,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef HILO_MDU_FLUSH_EN
  input  logic        flush,
`endif
  output logic        start,
  output logic        busy,
  output logic [31:0] HILO_out
);

  localparam logic [4:0] HILO_NONE  = 5'd0;
  localparam logic [4:0] HILO_MULT  = 5'd1;
  localparam logic [4:0] HILO_MULTU = 5'd2;
  localparam logic [4:0] HILO_DIV   = 5'd3;
  localparam logic [4:0] HILO_DIVU  = 5'd4;
  localparam logic [4:0] HILO_MTHI  = 5'd5;
  localparam logic [4:0] HILO_MTLO  = 5'd6;
  localparam logic [4:0] HILO_MFHI  = 5'd7;
  localparam logic [4:0] HILO_MFLO  = 5'd8;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic [31:0] pend_hi_r, pend_hi_s, pend_lo_r, pend_lo_s;
  logic        pend_we_r, pend_we_s;
  logic        busy_r;
  logic        start_s;
  logic        flush_s;
  logic [63:0] prod_s, divres_s;

`ifdef HILO_MDU_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // 64-bit product of sign- or zero-extended operands
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; signed case works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 without overflow.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ua = neg_a ? (32'd0 - a) : a;
    ub = neg_b ? (32'd0 - b) : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    q = (neg_a ^ neg_b) ? (32'd0 - q) : q;
    r = neg_a ? (32'd0 - r) : r;
    return {r, q};
  endfunction

  assign prod_s   = mul64(A, B, HILOType == HILO_MULT);
  assign divres_s = div64(A, B, HILOType == HILO_DIV);

  // Next-state, counter, HI/LO and pending-result logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_we_s = pend_we_r;
    start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_s) begin
          state_s = ST_IDLE;
        end else begin
          case (HILOType)
            HILO_MULT, HILO_MULTU: begin
              start_s   = 1'b1;
              state_s   = ST_BUSY;
              cnt_s     = 6'(MULT_CYCLES);
              pend_hi_s = prod_s[63:32];
              pend_lo_s = prod_s[31:0];
              pend_we_s = 1'b1;
            end
            HILO_DIV, HILO_DIVU: begin
              start_s   = 1'b1;
              state_s   = ST_BUSY;
              cnt_s     = 6'(DIV_CYCLES);
              pend_hi_s = divres_s[63:32];
              pend_lo_s = divres_s[31:0];
              // divide by zero still occupies the unit but leaves HI/LO alone
              pend_we_s = (B != 32'd0);
            end
            HILO_MTHI: hi_s = A;
            HILO_MTLO: lo_s = A;
            default:   state_s = ST_IDLE;
          endcase
        end
      end
      ST_BUSY: begin
        if (flush_s) begin
          state_s   = ST_IDLE;
          cnt_s     = 6'd0;
          pend_hi_s = 32'd0;
          pend_lo_s = 32'd0;
          pend_we_s = 1'b0;
        end else if (cnt_r == 6'd1) begin
          state_s = ST_IDLE;
          cnt_s   = 6'd0;
          if (pend_we_r) begin
            hi_s = pend_hi_r;
            lo_s = pend_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - 6'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_we_r <= pend_we_s;
      busy_r    <= (state_s == ST_BUSY);
    end
  end

  // HI/LO read port; reads never see pending results
  always_comb begin
    HILO_out = 32'd0;
    case (HILOType)
      HILO_MFHI: HILO_out = hi_r;
      HILO_MFLO: HILO_out = lo_r;
      HILO_NONE: HILO_out = 32'd0;
      default:   HILO_out = 32'd0;
    endcase
  end

  assign start = start_s;
  assign busy  = busy_r;

endmodule
